// File: rtl/bus512ton.sv
// -----------------------------------------------------------------------------
// bus512ton -- wide-to-narrow bus serializer.
//
// Accepts one IN_WIDTH-bit word at a time and emits it as 2^COUNT slices of
// OUT_WIDTH bits, least-significant slice first, one slice per cycle while the
// downstream side grants blob_dout_rdy. The next wide word may load on the
// same cycle the final slice of the current word leaves, so back-to-back words
// stream with no bubble. The end-of-packet qualifier rides only on the last
// slice of the word that carried it.
//
// Parameters
//   IN_WIDTH   width of the wide input word (must equal OUT_WIDTH * 2^COUNT)
//   OUT_WIDTH  width of each emitted slice
//   COUNT      phase counter width; slices per word = 2^COUNT
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   blob_din       wide data word
//   blob_din_rdy   high when a wide word can be accepted this cycle
//   blob_din_en    wide-word strobe (ignored while blob_din_rdy is low)
//   blob_din_eop   end-of-packet qualifier, sampled with blob_din_en
//   blob_dout      current narrow slice (0 while idle)
//   blob_dout_rdy  downstream permission to emit this cycle
//   blob_dout_en   slice-valid strobe
//   blob_dout_eop  marks the last slice of a packet
// -----------------------------------------------------------------------------
module bus512ton #(
  parameter int IN_WIDTH  = 512,
  parameter int OUT_WIDTH = 32,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  blob_din,
  output logic                 blob_din_rdy,
  input  logic                 blob_din_en,
  input  logic                 blob_din_eop,
  output logic [OUT_WIDTH-1:0] blob_dout,
  input  logic                 blob_dout_rdy,
  output logic                 blob_dout_en,
  output logic                 blob_dout_eop
);

  // EMPTY: nothing held. SHIFT: a word is held and being sliced out.
  typedef enum logic {
    EMPTY = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [COUNT-1:0]     phase;
  logic [IN_WIDTH-1:0]  data_q;
  logic                 eop_q;

  logic                 last_slice;
  logic                 accept;

  assign last_slice = &phase;
  assign accept     = blob_din_en & blob_din_rdy;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt defaults to the current state before the case so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (blob_din_en) state_nxt = SHIFT;
      SHIFT: begin
        // A load on the final slice keeps us in SHIFT with no idle cycle.
        if (accept)                             state_nxt = SHIFT;
        else if (blob_dout_rdy && last_slice)   state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    blob_din_rdy  = 1'b1;
    blob_dout_en  = 1'b0;
    blob_dout_eop = 1'b0;
    blob_dout     = '0;
    if (state == SHIFT) begin
      // Ready again only as the last slice is leaving, so the new word
      // replaces it on the same edge.
      blob_din_rdy  = blob_dout_rdy & last_slice;
      blob_dout_en  = blob_dout_rdy;
      blob_dout_eop = blob_dout_rdy & eop_q & last_slice;
      blob_dout     = data_q[phase*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: holding register, eop flag and slice phase
  // ---------------------------------------------------------------------------
  // NOTE: the wide holding register is reset along with the control state so
  // the block comes out of reset in a completely defined condition; a fresh
  // load always overwrites it before any slice is shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      eop_q  <= 1'b0;
      phase  <= '0;
    end else if (accept) begin
      data_q <= blob_din;
      eop_q  <= blob_din_eop;
      phase  <= '0;
    end else if (blob_dout_en) begin
      // Wraps naturally from all-ones to zero as the word finishes.
      phase  <= phase + 1'b1;
    end
  end

endmodule

// File: tb/tb_bus512ton.sv
// -----------------------------------------------------------------------------
// tb_bus512ton -- self-checking bench for bus512ton (default parameters).
// Inputs change on the falling edge; outputs are sampled 1 ns later, well away
// from the rising edge. A queue of pending slices serves as the reference.
// -----------------------------------------------------------------------------
module tb_bus512ton;

  localparam int IW  = 512;
  localparam int OW  = 32;
  localparam int CNT = 4;
  localparam int NS  = 1 << CNT;

  logic          clk;
  logic          rst;
  logic [IW-1:0] blob_din;
  logic          blob_din_rdy;
  logic          blob_din_en;
  logic          blob_din_eop;
  logic [OW-1:0] blob_dout;
  logic          blob_dout_rdy;
  logic          blob_dout_en;
  logic          blob_dout_eop;

  bus512ton #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COUNT(CNT)) dut (
    .clk           (clk),
    .rst           (rst),
    .blob_din      (blob_din),
    .blob_din_rdy  (blob_din_rdy),
    .blob_din_en   (blob_din_en),
    .blob_din_eop  (blob_din_eop),
    .blob_dout     (blob_dout),
    .blob_dout_rdy (blob_dout_rdy),
    .blob_dout_en  (blob_dout_en),
    .blob_dout_eop (blob_dout_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of slices still to be emitted ----
  typedef struct {
    logic [OW-1:0] d;
    logic          e;
  } slice_t;

  slice_t exp_q[$];

  task automatic push_word(input logic [IW-1:0] w, input logic eop);
    for (int k = 0; k < NS; k++) begin
      slice_t s;
      s.d = w[k*OW +: OW];
      s.e = eop && (k == NS - 1);
      exp_q.push_back(s);
    end
  endtask

  logic          obs_en, obs_eop, obs_rdy;
  logic [OW-1:0] obs_dout;

  // One clock cycle: called at a falling edge with inputs already applied.
  task automatic step(input string tag, output logic acc);
    logic          m_rdy, m_en, m_eop;
    logic [OW-1:0] m_dout;
    int            n;
    #1;
    n      = exp_q.size();
    m_rdy  = (n == 0) || (n == 1 && blob_dout_rdy);
    m_en   = (n != 0) && blob_dout_rdy;
    m_dout = (n != 0) ? exp_q[0].d : '0;
    m_eop  = (n != 0) ? (m_en && exp_q[0].e) : 1'b0;
    obs_en = blob_dout_en; obs_eop = blob_dout_eop;
    obs_rdy = blob_din_rdy; obs_dout = blob_dout;
    check({tag, "_rdy"},  64'(blob_din_rdy),  64'(m_rdy));
    check({tag, "_en"},   64'(blob_dout_en),  64'(m_en));
    check({tag, "_eop"},  64'(blob_dout_eop), 64'(m_eop));
    check({tag, "_dout"}, 64'(blob_dout),     64'(m_dout));
    acc = blob_din_en && m_rdy;
    @(posedge clk);
    if (m_en) void'(exp_q.pop_front());
    if (acc) push_word(blob_din, blob_din_eop);
    @(negedge clk);
  endtask

  function automatic logic [IW-1:0] rand_word();
    logic [IW-1:0] w;
    for (int k = 0; k < IW / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    blob_din_en = 1'b0;
    #2;
    check("reset_rdy",  64'(blob_din_rdy),  64'd1);
    check("reset_en",   64'(blob_dout_en),  64'd0);
    check("reset_eop",  64'(blob_dout_eop), 64'd0);
    check("reset_dout", 64'(blob_dout),     64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- directed table: single word with a backpressure gap ----
  typedef struct {
    logic          din_en, din_eop, dout_rdy;
    logic          exp_rdy, exp_en, exp_eop;
    logic [OW-1:0] exp_dout;
  } vec_t;

  function automatic vec_t mk(input logic di, de, dr, er, ee, eo, input int ed);
    vec_t v;
    v.din_en = di; v.din_eop = de; v.dout_rdy = dr;
    v.exp_rdy = er; v.exp_en = ee; v.exp_eop = eo; v.exp_dout = OW'(ed);
    return v;
  endfunction

  // Watchdog: the whole run is a few tens of microseconds.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[$];
    logic [IW-1:0] ramp, wa, wb, w0, w1;
    logic          acc;
    int            p, en_cnt, first_en, last_en, cyc;
    logic [OW-1:0] nw[20];
    slice_t        got[$];

    rst = 1'b1; blob_din = '0; blob_din_en = 1'b0; blob_din_eop = 1'b0;
    blob_dout_rdy = 1'b1;
    @(negedge clk);
    do_reset();

    // Slice k of the ramp word holds the value k.
    for (int k = 0; k < NS; k++) ramp[k*OW +: OW] = OW'(k);

    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));             // idle
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0));             // accept, eop=1
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 1, 0, 1, 0, k));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 5));  // stall at 5
    for (int k = 5; k < NS - 1; k++) vecs.push_back(mk(0, 0, 1, 0, 1, 0, k));
    vecs.push_back(mk(0, 0, 1, 1, 1, 1, NS - 1));        // last slice, eop
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0));             // idle again

    blob_din = ramp;
    foreach (vecs[i]) begin
      blob_din_en   = vecs[i].din_en;
      blob_din_eop  = vecs[i].din_eop;
      blob_dout_rdy = vecs[i].dout_rdy;
      #1;
      check($sformatf("vec%0d_rdy", i),  64'(blob_din_rdy),  64'(vecs[i].exp_rdy));
      check($sformatf("vec%0d_en", i),   64'(blob_dout_en),  64'(vecs[i].exp_en));
      check($sformatf("vec%0d_eop", i),  64'(blob_dout_eop), 64'(vecs[i].exp_eop));
      check($sformatf("vec%0d_dout", i), 64'(blob_dout),     64'(vecs[i].exp_dout));
      @(posedge clk);
      @(negedge clk);
    end

    // ---------------- back-to-back words ----------------
    do_reset();
    wa = rand_word(); wb = rand_word();
    p = 0; en_cnt = 0; first_en = -1; last_en = -1;
    blob_dout_rdy = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      blob_din     = (p == 0) ? wa : wb;
      blob_din_eop = (p == 1);
      blob_din_en  = (p < 2);
      step("b2b", acc);
      if (acc) p++;
      if (obs_en) begin
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        if (en_cnt == NS) check("b2b_rdy_at_slice15", 64'(obs_rdy), 64'd1);
        if (en_cnt == NS - 1) check("b2b_rdy_before_slice15", 64'(obs_rdy), 64'd0);
      end
    end
    check("b2b_en_count", 64'(en_cnt), 64'd32);
    check("b2b_contiguous", 64'(last_en - first_en + 1), 64'd32);

    // ---------------- protocol violation at phase 3 ----------------
    do_reset();
    blob_din = rand_word(); blob_din_eop = 1'b1; blob_din_en = 1'b1;
    step("viol_load", acc);
    blob_din_en = 1'b0;
    for (int k = 0; k < 3; k++) step("viol_pre", acc);
    blob_din = rand_word(); blob_din_eop = 1'b0; blob_din_en = 1'b1;
    step("viol_inject", acc);
    check("viol_ignored", 64'(acc), 64'd0);
    blob_din_en = 1'b0;
    for (int k = 0; k < NS; k++) step("viol_post", acc);

    // ---------------- async reset at phase 7 ----------------
    do_reset();
    blob_din = rand_word(); blob_din_eop = 1'b1; blob_din_en = 1'b1;
    step("arst_load", acc);
    blob_din_en = 1'b0;
    for (int k = 0; k < 7; k++) step("arst_pre", acc);
    #1;
    check("arst_phase7", 64'(blob_dout), 64'(exp_q[0].d));
    #1;
    rst = 1'b1;
    #1;
    check("arst_dout", 64'(blob_dout),     64'd0);
    check("arst_en",   64'(blob_dout_en),  64'd0);
    check("arst_eop",  64'(blob_dout_eop), 64'd0);
    check("arst_rdy",  64'(blob_din_rdy),  64'd1);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    blob_din = rand_word(); blob_din_eop = 1'b0; blob_din_en = 1'b1;
    step("arst_reload", acc);
    blob_din_en = 1'b0;
    for (int k = 0; k < NS + 2; k++) step("arst_post", acc);

    // ---------------- round trip from a 32->512 packer ----------------
    do_reset();
    for (int i = 0; i < 20; i++) nw[i] = $urandom;
    w0 = '0; w1 = '0;
    for (int i = 0; i < 16; i++) w0[i*OW +: OW] = nw[i];
    for (int i = 16; i < 20; i++) w1[(i-16)*OW +: OW] = nw[i];
    p = 0;
    for (cyc = 0; cyc < 40; cyc++) begin
      blob_din     = (p == 0) ? w0 : w1;
      blob_din_eop = (p == 1);
      blob_din_en  = (p < 2);
      blob_dout_rdy = 1'b1;
      step("rt", acc);
      if (acc) p++;
      if (obs_en) begin
        slice_t s;
        s.d = obs_dout; s.e = obs_eop;
        got.push_back(s);
      end
    end
    check("rt_count", 64'(got.size()), 64'd32);
    for (int i = 0; i < 32 && i < got.size(); i++) begin
      check($sformatf("rt_data%0d", i), 64'(got[i].d), 64'((i < 20) ? nw[i] : 32'd0));
      check($sformatf("rt_eop%0d", i),  64'(got[i].e), 64'(i == 31));
    end

    // ---------------- randomized traffic ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      blob_din      = rand_word();
      blob_din_en   = ($urandom_range(0, 2) == 0);
      blob_din_eop  = $urandom_range(0, 1) == 1;
      blob_dout_rdy = ($urandom_range(0, 3) != 0);
      step("rnd", acc);
    end
    blob_din_en = 1'b0; blob_dout_rdy = 1'b1;
    for (int i = 0; i < NS + 2; i++) step("rnd_drain", acc);
    check("rnd_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
